// File: rtl/microsequencer_stack.sv
// microsequencer_stack
//   Registered microsequencer for the Y86 microcoded control unit. It holds the
//   current microstate and picks the next microaddress from a 3-bit select code.
//   The select code covers hold, jump, two memory-ready waits with a timeout,
//   microsubroutine call/return on a small return stack, conditional branch and
//   increment.
//   A fault (stack overflow, stack underflow or wait timeout) diverts the
//   sequencer to FAULT_STATE. It also sets a sticky flag and latches the cause
//   of the first fault.
// Ports:
//   clk, reset      rising-edge clock, asynchronous active-high reset
//   sel             next-state select code
//   valN            target microaddress from the control ROM
//   icode           opcode used for WAIT_I dispatch
//   cond            branch condition
//   DMemReady       data memory ready (WAIT_D)
//   IMemReady       instruction memory ready (WAIT_I)
//   timeout_limit   stalled cycles before a timeout fault; 0 disables the timeout
//   state           registered microstate
//   nextState       combinational next microstate
//   waiting         a WAIT select is stalling this cycle and no fault is taken
//   fault           sticky fault flag
//   fault_cause     0 none, 1 overflow, 2 underflow, 3 timeout (first fault only)
//   depth           number of valid return-stack entries
module microsequencer_stack #(
  parameter int unsigned        STATE_W       = 6,
  parameter int unsigned        OPC_W         = 4,
  parameter logic [STATE_W-1:0] DISPATCH_BASE = 6'b110000,
  parameter logic [STATE_W-1:0] RESET_STATE   = '0,
  parameter logic [STATE_W-1:0] FAULT_STATE   = 6'b001111,
  parameter int unsigned        STACK_DEPTH   = 4,
  parameter int unsigned        TIMEOUT_W     = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [2:0]                   sel,
  input  logic [STATE_W-1:0]           valN,
  input  logic [OPC_W-1:0]             icode,
  input  logic                         cond,
  input  logic                         DMemReady,
  input  logic                         IMemReady,
  input  logic [TIMEOUT_W-1:0]         timeout_limit,
  output logic [STATE_W-1:0]           state,
  output logic [STATE_W-1:0]           nextState,
  output logic                         waiting,
  output logic                         fault,
  output logic [1:0]                   fault_cause,
  output logic [$clog2(STACK_DEPTH):0] depth
);

  localparam int unsigned AW = $clog2(STACK_DEPTH);
  localparam int unsigned DW = AW + 1;

  typedef enum logic [2:0] {
    SEL_HOLD   = 3'd0,
    SEL_JUMP   = 3'd1,
    SEL_WAIT_D = 3'd2,
    SEL_WAIT_I = 3'd3,
    SEL_CALL   = 3'd4,
    SEL_RET    = 3'd5,
    SEL_BRANCH = 3'd6,
    SEL_INC    = 3'd7
  } selT;

  typedef enum logic [1:0] {
    CAUSE_NONE = 2'd0,
    CAUSE_OVF  = 2'd1,
    CAUSE_UNF  = 2'd2,
    CAUSE_TMO  = 2'd3
  } causeT;

  logic [STATE_W-1:0]   stackMem [STACK_DEPTH];
  logic [STATE_W-1:0]   inc;
  logic [STATE_W-1:0]   dispatchAddr;
  logic [AW-1:0]        topIdx;
  logic [TIMEOUT_W-1:0] waitCnt;
  logic                 stalled;
  logic                 timeoutFire;
  logic                 push;
  logic                 pop;
  logic                 ovf;
  logic                 unf;
  logic                 faultNow;
  causeT                faultCause;
  causeT                newCause;

  assign inc          = state + STATE_W'(1);
  assign dispatchAddr = DISPATCH_BASE | STATE_W'(icode);
  // The top entry sits one below the stack pointer. When the stack is full the
  // low bits of depth are zero, so the subtraction wraps to the last slot.
  assign topIdx       = depth[AW-1:0] - AW'(1);

  assign stalled     = ((sel == 3'd2) && !DMemReady) || ((sel == 3'd3) && !IMemReady);
  assign timeoutFire = stalled && (timeout_limit != '0) &&
                       (waitCnt == timeout_limit - TIMEOUT_W'(1));
  assign waiting     = stalled && !timeoutFire;

  always_comb begin
    nextState = state;
    push      = 1'b0;
    pop       = 1'b0;
    ovf       = 1'b0;
    unf       = 1'b0;
    case (selT'(sel))
      SEL_HOLD:   nextState = state;
      SEL_JUMP:   nextState = valN;
      SEL_WAIT_D: if (DMemReady) nextState = valN;
      SEL_WAIT_I: if (IMemReady) nextState = dispatchAddr;
      SEL_CALL: begin
        if (depth == DW'(STACK_DEPTH)) begin
          ovf = 1'b1;
        end else begin
          push      = 1'b1;
          nextState = valN;
        end
      end
      SEL_RET: begin
        if (depth == '0) begin
          unf = 1'b1;
        end else begin
          pop       = 1'b1;
          nextState = stackMem[topIdx];
        end
      end
      SEL_BRANCH: nextState = cond ? valN : inc;
      SEL_INC:    nextState = inc;
      default:    nextState = state;
    endcase
    if (ovf || unf || timeoutFire) nextState = FAULT_STATE;
  end

  assign faultNow = ovf || unf || timeoutFire;
  assign newCause = ovf ? CAUSE_OVF : (unf ? CAUSE_UNF : CAUSE_TMO);

  // The stack contents are not reset. Only the pointer (depth) decides which
  // entries are valid.
  always_ff @(posedge clk) begin
    if (push) stackMem[depth[AW-1:0]] <= inc;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= RESET_STATE;
      depth      <= '0;
      waitCnt    <= '0;
      fault      <= 1'b0;
      faultCause <= CAUSE_NONE;
    end else begin
      state   <= nextState;
      waitCnt <= waiting ? waitCnt + TIMEOUT_W'(1) : '0;
      if (push)     depth <= depth + DW'(1);
      else if (pop) depth <= depth - DW'(1);
      if (faultNow) begin
        fault <= 1'b1;
        if (!fault) faultCause <= newCause;
      end
    end
  end

  assign fault_cause = faultCause;

endmodule

// File: doc/microsequencer_stack.md
Name: microsequencer_stack

Overview:
Registered, parametrised microsequencer for the Y86 microcoded control unit. It owns the current microstate register and computes the next microaddress from an extended select code: hold, jump, increment, conditional branch, memory-ready waits with timeout, opcode dispatch, and microsubroutine call/return on a small internal return stack. Faults (stack overflow/underflow, wait timeout) divert the sequencer to a fixed fault microaddress and raise a sticky flag for the control ROM and debug logic.

Parameters:
STATE_W, 6, microstate/microaddress width
OPC_W, 4, icode width; STATE_W >= OPC_W is required
DISPATCH_BASE, 6'b110000, base OR'd with the zero-extended icode on dispatch
RESET_STATE, 0, microstate loaded on reset
FAULT_STATE, 6'b001111, microstate entered on any fault
STACK_DEPTH, 4, return-stack entries (power of 2, >= 2)
TIMEOUT_W, 8, wait-timeout counter width

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
sel  input  3  next-state select code (encoding below)
valN  input  STATE_W  target microaddress from the control ROM
icode  input  OPC_W  instruction opcode for dispatch
cond  input  1  branch condition for BRANCH
DMemReady  input  1  data memory ready
IMemReady  input  1  instruction memory ready
timeout_limit  input  TIMEOUT_W  wait cycles before timeout fault; 0 disables timeout
state  output  STATE_W  current microstate (registered)
nextState  output  STATE_W  combinational next microstate
waiting  output  1  high when a WAIT select is stalling (ready low, no fault)
fault  output  1  sticky fault flag
fault_cause  output  2  0=none, 1=overflow, 2=underflow, 3=timeout; latched with the first fault
depth  output  clog2(STACK_DEPTH)+1  number of valid return-stack entries

Behaviour:
- Reset (async, active-high): state=RESET_STATE, stack pointer=0 (depth=0), wait counter=0, fault=0, fault_cause=0. Stack contents are don't-care. Reset mid-call or mid-wait discards all pending context.
- state<=nextState on every rising clk edge. There is one cycle of latency from sel to state.
- inc = state+1, modulo 2^STATE_W. 6'h3F+1 wraps to 0.
- sel encoding:
  - 0 HOLD: state.
  - 1 JUMP: valN.
  - 2 WAIT_D: DMemReady ? valN : state.
  - 3 WAIT_I: IMemReady ? (DISPATCH_BASE | zero-extended icode) : state.
  - 4 CALL: push inc, then valN.
  - 5 RET: pop the top entry and go to it.
  - 6 BRANCH: cond ? valN : inc.
  - 7 INC: inc.
- Wait counter: increments each cycle that sel is 2 or 3 with the matching ready low. It clears whenever ready is high, sel is not a WAIT, or a fault is taken.
  - When timeout_limit != 0 and the counter equals timeout_limit-1 while still stalled, nextState=FAULT_STATE and a timeout fault is raised. The fault state is therefore entered after exactly timeout_limit stalled cycles.
  - Ready high on that same cycle wins: normal advance, no fault.
- CALL with depth==STACK_DEPTH: no push, nextState=FAULT_STATE, overflow fault.
- RET with depth==0: no pop, nextState=FAULT_STATE, underflow fault.
- A successful CALL increments depth by one. A successful RET decrements depth by one. The stack is LIFO.
- fault is set on the edge that enters FAULT_STATE because of a fault and stays set until reset. fault_cause records only the first fault; later faults do not overwrite it. Sequencing continues normally after a fault, driven by the microcode at FAULT_STATE.
- waiting = (sel==2 & ~DMemReady | sel==3 & ~IMemReady) & ~(timeout firing this cycle).
- An sel value equal to X is not defined behaviour. The sequencer needs no sel pattern checks beyond the 3-bit decode.

Test Plan:
1. Reset, then sel=7 for 3 cycles -> state 0,1,2,3. Load state=6'h3F via JUMP, then INC -> state=0.
2. state=5, sel=3, icode=4'h6, IMemReady low for 2 cycles then high -> state holds 5 for 2 cycles with waiting=1, then becomes 6'h36 with waiting=0.
3. Nested calls with STACK_DEPTH=4:
   - CALL valN=10 from state 2, then CALL valN=20 from state 10, then RET, RET -> states 10,20,11,3; depth goes 1,2,1,0.
   - Four further CALLs reach depth 4. A fifth CALL -> state=FAULT_STATE, fault=1, fault_cause=1, depth stays 4.
4. After reset, sel=5 -> state=FAULT_STATE, fault_cause=2. A subsequent overflow leaves fault_cause=2.
5. timeout_limit=3, sel=2, DMemReady held low -> FAULT_STATE after exactly 3 stalled cycles, fault_cause=3.
   - Repeat with DMemReady rising on the 3rd stalled cycle -> state=valN, no fault.
   - Repeat with timeout_limit=0 and DMemReady low for 300 cycles -> no fault.
6. Assert reset asynchronously (not aligned to clk) during a wait at depth 2 -> state=RESET_STATE, depth=0 and fault=0 immediately, without waiting for a clock edge.
